// File: rtl/layer_sequencer_if.sv
// -----------------------------------------------------------------------------
// layer_sequencer_if
// Bundles the command, configuration and handshake signals between the layer
// sequencer and its surroundings (host, config table, weight memory, conv unit).
//   master : drives start/abort/config/valids, observes the state broadcast
//   slave  : the sequencer itself
// Signals:
//   start, abort                 run control from the host
//   num_layers_in                layer count minus one, latched on start
//   cfg_weight_words_in          weight words for layer layer_idx_out
//   cfg_out_pixels_in            output pixels for layer layer_idx_out
//   weight_valid_in              one weight word accepted by weight memory
//   mac_valid_in                 one output pixel produced by the conv unit
//   current_state, state_rst     state broadcast and new-state pulse
//   layer_idx_out                current layer index
//   weight_load_en, calc_en      phase enables
//   busy, done                   run status
// -----------------------------------------------------------------------------
interface layer_sequencer_if #(
    parameter int STATE_WIDTH     = 3,
    parameter int LAYER_IDX_WIDTH = 3,
    parameter int CNT_WIDTH       = 16
);
    logic                       start;
    logic                       abort;
    logic [LAYER_IDX_WIDTH-1:0] num_layers_in;
    logic [CNT_WIDTH-1:0]       cfg_weight_words_in;
    logic [CNT_WIDTH-1:0]       cfg_out_pixels_in;
    logic                       weight_valid_in;
    logic                       mac_valid_in;
    logic [STATE_WIDTH-1:0]     current_state;
    logic                       state_rst;
    logic [LAYER_IDX_WIDTH-1:0] layer_idx_out;
    logic                       weight_load_en;
    logic                       calc_en;
    logic                       busy;
    logic                       done;

    modport master (
        output start, abort, num_layers_in, cfg_weight_words_in, cfg_out_pixels_in,
               weight_valid_in, mac_valid_in,
        input  current_state, state_rst, layer_idx_out, weight_load_en, calc_en,
               busy, done
    );

    modport slave (
        input  start, abort, num_layers_in, cfg_weight_words_in, cfg_out_pixels_in,
               weight_valid_in, mac_valid_in,
        output current_state, state_rst, layer_idx_out, weight_load_en, calc_en,
               busy, done
    );
endinterface

// File: rtl/layer_sequencer.sv
// -----------------------------------------------------------------------------
// layer_sequencer
// Layer-level controller for the CNN accelerator. One start runs
// num_layers_in+1 layers; each layer goes CFG -> LOAD -> CALC -> DRAIN -> NEXT,
// and DONE is held for one cycle after the last layer.
// Ports:
//   clk   : rising-edge clock
//   rstn  : synchronous active-low reset
//   bus   : layer_sequencer_if.slave (command, config, valids, state outputs)
// All outputs are registers loaded from the next-state value, so they change
// only on the clock edge and line up with current_state.
// -----------------------------------------------------------------------------
module layer_sequencer #(
    parameter int STATE_WIDTH     = 3,
    parameter int LAYER_IDX_WIDTH = 3,
    parameter int CNT_WIDTH       = 16,
    parameter int DRAIN_CYCLES    = 4
) (
    input  logic               clk,
    input  logic               rstn,
    layer_sequencer_if.slave   bus
);
    typedef enum logic [STATE_WIDTH-1:0] {
        ST_IDLE  = STATE_WIDTH'(0),
        ST_CFG   = STATE_WIDTH'(1),
        ST_LOAD  = STATE_WIDTH'(2),
        ST_CALC  = STATE_WIDTH'(3),
        ST_DRAIN = STATE_WIDTH'(4),
        ST_NEXT  = STATE_WIDTH'(5),
        ST_DONE  = STATE_WIDTH'(6)
    } state_t;

    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

    state_t                     state_reg, state_next;
    logic [LAYER_IDX_WIDTH-1:0] layer_idx_reg, layer_idx_next;
    logic [LAYER_IDX_WIDTH-1:0] num_layers_reg, num_layers_next;
    logic [CNT_WIDTH-1:0]       words_reg, words_next;
    logic [CNT_WIDTH-1:0]       pixels_reg, pixels_next;
    logic [CNT_WIDTH-1:0]       wcnt_reg, wcnt_next, wcnt_inc;
    logic [CNT_WIDTH-1:0]       pcnt_reg, pcnt_next, pcnt_inc;
    logic [DRAIN_W-1:0]         drain_cnt_reg, drain_cnt_next;

    logic state_rst_reg;
    logic weight_load_en_reg;
    logic calc_en_reg;
    logic busy_reg;
    logic done_reg;

    always_comb begin
        state_next      = state_reg;
        layer_idx_next  = layer_idx_reg;
        num_layers_next = num_layers_reg;
        words_next      = words_reg;
        pixels_next     = pixels_reg;
        wcnt_next       = wcnt_reg;
        pcnt_next       = pcnt_reg;
        drain_cnt_next  = '0;
        // Targets are compared against the post-increment value so a
        // full-scale target never needs the counter to wrap.
        wcnt_inc        = wcnt_reg + 1'b1;
        pcnt_inc        = pcnt_reg + 1'b1;

        case (state_reg)
            ST_IDLE: begin
                // abort in IDLE blocks a simultaneous start
                if (bus.start && !bus.abort) begin
                    num_layers_next = bus.num_layers_in;
                    layer_idx_next  = '0;
                    state_next      = ST_CFG;
                end
            end
            ST_CFG: begin
                words_next  = bus.cfg_weight_words_in;
                pixels_next = bus.cfg_out_pixels_in;
                wcnt_next   = '0;
                pcnt_next   = '0;
                state_next  = (bus.cfg_weight_words_in == '0) ? ST_CALC : ST_LOAD;
            end
            ST_LOAD: begin
                if (bus.weight_valid_in) begin
                    wcnt_next = wcnt_inc;
                    if (wcnt_inc == words_reg)
                        state_next = (pixels_reg == '0) ? ST_DRAIN : ST_CALC;
                end
            end
            ST_CALC: begin
                // A zero pixel target is already met: spend one cycle in CALC.
                if (pixels_reg == '0) begin
                    state_next = ST_DRAIN;
                end else if (bus.mac_valid_in) begin
                    pcnt_next = pcnt_inc;
                    if (pcnt_inc == pixels_reg)
                        state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_reg == DRAIN_LAST)
                    state_next = ST_NEXT;
                else
                    drain_cnt_next = drain_cnt_reg + 1'b1;
            end
            ST_NEXT: begin
                if (layer_idx_reg == num_layers_reg) begin
                    state_next = ST_DONE;
                end else begin
                    layer_idx_next = layer_idx_reg + 1'b1;
                    state_next     = ST_CFG;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;   // unused code 7 recovers to IDLE
        endcase

        if (bus.abort && (state_reg != ST_IDLE)) begin
            state_next     = ST_IDLE;
            layer_idx_next = '0;
            wcnt_next      = '0;
            pcnt_next      = '0;
            drain_cnt_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg          <= ST_IDLE;
            layer_idx_reg      <= '0;
            num_layers_reg     <= '0;
            words_reg          <= '0;
            pixels_reg         <= '0;
            wcnt_reg           <= '0;
            pcnt_reg           <= '0;
            drain_cnt_reg      <= '0;
            state_rst_reg      <= 1'b0;
            weight_load_en_reg <= 1'b0;
            calc_en_reg        <= 1'b0;
            busy_reg           <= 1'b0;
            done_reg           <= 1'b0;
        end else begin
            state_reg          <= state_next;
            layer_idx_reg      <= layer_idx_next;
            num_layers_reg     <= num_layers_next;
            words_reg          <= words_next;
            pixels_reg         <= pixels_next;
            wcnt_reg           <= wcnt_next;
            pcnt_reg           <= pcnt_next;
            drain_cnt_reg      <= drain_cnt_next;
            state_rst_reg      <= (state_next != state_reg);
            weight_load_en_reg <= (state_next == ST_LOAD);
            calc_en_reg        <= (state_next == ST_CALC);
            busy_reg           <= (state_next != ST_IDLE);
            done_reg           <= (state_next == ST_DONE);
        end
    end

    assign bus.current_state  = state_reg;
    assign bus.state_rst      = state_rst_reg;
    assign bus.layer_idx_out  = layer_idx_reg;
    assign bus.weight_load_en = weight_load_en_reg;
    assign bus.calc_en        = calc_en_reg;
    assign bus.busy           = busy_reg;
    assign bus.done           = done_reg;
endmodule

// File: tb/tb_layer_sequencer.sv
// -----------------------------------------------------------------------------
// tb_layer_sequencer
// Self-checking bench for layer_sequencer. For each run the reference model
// walks the per-layer word/pixel table and the per-cycle valid stimulus to
// build the expected state/layer trace, then the run is replayed against the
// DUT and every output is compared each cycle.
// -----------------------------------------------------------------------------
module tb_layer_sequencer;
    localparam int SW = 3;
    localparam int LW = 3;
    localparam int CW = 16;
    localparam int DR = 4;
    localparam int N  = 1024;

    localparam int S_IDLE  = 0;
    localparam int S_CFG   = 1;
    localparam int S_LOAD  = 2;
    localparam int S_CALC  = 3;
    localparam int S_DRAIN = 4;
    localparam int S_NEXT  = 5;
    localparam int S_DONE  = 6;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    layer_sequencer_if #(.STATE_WIDTH(SW), .LAYER_IDX_WIDTH(LW), .CNT_WIDTH(CW)) bus ();

    layer_sequencer #(
        .STATE_WIDTH    (SW),
        .LAYER_IDX_WIDTH(LW),
        .CNT_WIDTH      (CW),
        .DRAIN_CYCLES   (DR)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // External per-layer config table, indexed by the DUT's layer index.
    int words_tab [8];
    int pix_tab   [8];
    assign bus.cfg_weight_words_in = CW'(words_tab[bus.layer_idx_out]);
    assign bus.cfg_out_pixels_in   = CW'(pix_tab[bus.layer_idx_out]);

    // Per-cycle stimulus and expected trace for one run (index 0 = start cycle)
    bit wv [N];
    bit mv [N];
    bit st [N];
    bit ab [N];
    bit rs [N];
    int exp_state [N];
    int exp_idx   [N];

    int n_checks = 0;
    int n_errors = 0;
    int run_id   = 0;
    int done_at;

    task automatic check(input string tag, input int obs, input int exp_val);
        n_checks++;
        if (obs !== exp_val) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic guard(input int c);
        if (c >= N - 8) begin
            $display("FAIL model: run %0d exceeds %0d-cycle budget", run_id, N);
            $fatal(1, "cycle budget exceeded");
        end
    endtask

    task automatic clear_stim();
        for (int k = 0; k < N; k++) begin
            wv[k] = 1'b0; mv[k] = 1'b0; st[k] = 1'b0; ab[k] = 1'b0; rs[k] = 1'b0;
        end
    endtask

    task automatic random_valids();
        for (int k = 0; k < N; k++) begin
            wv[k] = 1'($urandom_range(0, 1));
            mv[k] = 1'($urandom_range(0, 1));
        end
    endtask

    // mode 0: clean run, 1: abort on 2nd counted CALC valid of layer 1,
    // 2: reset in first LOAD cycle, 3: abort at a random busy cycle
    task automatic run_layers(input int nl, input bit spur, input int mode, output int done_cyc);
        int c, cnt, done_k, cut, last, ndone_exp, ndone_obs, rst_exp;
        for (int k = 0; k < N; k++) begin
            exp_state[k] = S_IDLE;
            exp_idx[k]   = -1;
        end
        c = 1;
        for (int l = 0; l <= nl; l++) begin
            exp_state[c] = S_CFG; exp_idx[c] = l; c++;
            if (words_tab[l] != 0) begin
                cnt = 0;
                while (cnt < words_tab[l]) begin
                    exp_state[c] = S_LOAD; exp_idx[c] = l;
                    if (wv[c]) cnt++;
                    c++; guard(c);
                end
            end
            if (words_tab[l] == 0 || pix_tab[l] != 0) begin
                if (pix_tab[l] == 0) begin
                    exp_state[c] = S_CALC; exp_idx[c] = l; c++;
                end else begin
                    cnt = 0;
                    while (cnt < pix_tab[l]) begin
                        exp_state[c] = S_CALC; exp_idx[c] = l;
                        if (mv[c]) cnt++;
                        c++; guard(c);
                    end
                end
            end
            for (int d = 0; d < DR; d++) begin
                exp_state[c] = S_DRAIN; exp_idx[c] = l; c++;
            end
            exp_state[c] = S_NEXT; exp_idx[c] = l; c++;
            guard(c);
        end
        done_k = c;
        exp_state[done_k] = S_DONE; exp_idx[done_k] = nl;
        last = done_k + 2;
        cut  = -1;

        if (mode == 1) begin
            cnt = 0;
            for (int k = 1; k <= done_k; k++)
                if (exp_state[k] == S_CALC && exp_idx[k] == 1 && mv[k]) begin
                    cnt++;
                    if (cnt == 2 && cut < 0) cut = k;
                end
            if (cut < 0) begin
                $display("FAIL setup: no second CALC valid on layer 1 in run %0d", run_id);
                $fatal(1, "bad abort setup");
            end
        end else if (mode == 2) begin
            for (int k = done_k; k >= 1; k--)
                if (exp_state[k] == S_LOAD) cut = k;
            if (cut < 0) begin
                $display("FAIL setup: no LOAD cycle in run %0d", run_id);
                $fatal(1, "bad reset setup");
            end
        end else if (mode == 3) begin
            cut = $urandom_range(1, done_k);
        end

        if (cut > 0) begin
            if (mode == 2) rs[cut] = 1'b1;
            else           ab[cut] = 1'b1;
            for (int k = cut + 1; k < N; k++) begin
                exp_state[k] = S_IDLE;
                exp_idx[k]   = (k <= cut + 3) ? 0 : -1;
            end
            last = cut + 3;
        end

        if (spur)
            for (int k = 1; k <= last; k++)
                if (exp_state[k] != S_IDLE && $urandom_range(0, 7) == 0) st[k] = 1'b1;

        ndone_exp = 0;
        for (int k = 0; k <= last; k++)
            if (exp_state[k] == S_DONE) ndone_exp++;

        done_cyc  = -1;
        ndone_obs = 0;
        for (int k = 0; k <= last; k++) begin
            if (k == 0)
                rst_exp = 0;
            else
                rst_exp = (exp_state[k] != exp_state[k-1] && !(mode == 2 && k == cut + 1)) ? 1 : 0;
            check($sformatf("r%0d c%0d state", run_id, k), int'(bus.current_state), exp_state[k]);
            check($sformatf("r%0d c%0d state_rst", run_id, k), int'(bus.state_rst), rst_exp);
            check($sformatf("r%0d c%0d busy", run_id, k), int'(bus.busy), (exp_state[k] != S_IDLE) ? 1 : 0);
            check($sformatf("r%0d c%0d done", run_id, k), int'(bus.done), (exp_state[k] == S_DONE) ? 1 : 0);
            check($sformatf("r%0d c%0d weight_load_en", run_id, k), int'(bus.weight_load_en), (exp_state[k] == S_LOAD) ? 1 : 0);
            check($sformatf("r%0d c%0d calc_en", run_id, k), int'(bus.calc_en), (exp_state[k] == S_CALC) ? 1 : 0);
            if (exp_idx[k] >= 0)
                check($sformatf("r%0d c%0d layer_idx", run_id, k), int'(bus.layer_idx_out), exp_idx[k]);
            if (bus.done) begin
                ndone_obs++;
                if (done_cyc < 0) done_cyc = k;
            end
            bus.start           = (k == 0) || st[k];
            bus.abort           = ab[k];
            bus.weight_valid_in = wv[k];
            bus.mac_valid_in    = mv[k];
            rstn                = !rs[k];
            // The count must be latched on start; scramble it afterwards.
            bus.num_layers_in   = (k == 0) ? LW'(nl) : LW'($urandom_range(0, 7));
            tick();
        end
        bus.start = 1'b0; bus.abort = 1'b0;
        bus.weight_valid_in = 1'b0; bus.mac_valid_in = 1'b0;
        rstn = 1'b1;
        check($sformatf("r%0d done_count", run_id), ndone_obs, ndone_exp);
        $display("run %0d: layers=%0d mode=%0d cycles=%0d done_at=%0d", run_id, nl + 1, mode, last + 1, done_cyc);
        run_id++;
    endtask

    initial begin
        bus.start = 1'b0; bus.abort = 1'b0; bus.num_layers_in = '0;
        bus.weight_valid_in = 1'b0; bus.mac_valid_in = 1'b0;
        for (int i = 0; i < 8; i++) begin words_tab[i] = 0; pix_tab[i] = 0; end
        rstn = 1'b0;
        repeat (3) tick();
        check("reset state", int'(bus.current_state), S_IDLE);
        check("reset state_rst", int'(bus.state_rst), 0);
        check("reset layer_idx", int'(bus.layer_idx_out), 0);
        check("reset weight_load_en", int'(bus.weight_load_en), 0);
        check("reset calc_en", int'(bus.calc_en), 0);
        check("reset busy", int'(bus.busy), 0);
        check("reset done", int'(bus.done), 0);
        rstn = 1'b1;
        tick();

        // abort together with start in IDLE: no run
        bus.start = 1'b1; bus.abort = 1'b1;
        tick();
        bus.start = 1'b0; bus.abort = 1'b0;
        check("idle abort state", int'(bus.current_state), S_IDLE);
        check("idle abort busy", int'(bus.busy), 0);
        check("idle abort state_rst", int'(bus.state_rst), 0);
        tick();

        // single layer reference: words=3, pixels=2
        words_tab[0] = 3; pix_tab[0] = 2;
        clear_stim();
        wv[3] = 1; wv[4] = 1; wv[5] = 1; mv[7] = 1; mv[8] = 1;
        run_layers(0, 1'b0, 0, done_at);
        check("single done cycle", done_at, 14);

        // zero sizes: CFG -> CALC -> DRAIN
        words_tab[0] = 0; pix_tab[0] = 0;
        clear_stim(); random_valids();
        run_layers(0, 1'b0, 0, done_at);
        check("zero done cycle", done_at, 3 + DR + 1);

        // three layers with distinct sizes
        words_tab[0] = 2; pix_tab[0] = 5;
        words_tab[1] = 4; pix_tab[1] = 1;
        words_tab[2] = 0; pix_tab[2] = 3;
        clear_stim(); random_valids();
        run_layers(2, 1'b0, 0, done_at);

        // spurious valids in IDLE/CFG/LOAD/CALC/DRAIN and start during CALC
        words_tab[0] = 3; pix_tab[0] = 2;
        clear_stim();
        wv[3] = 1; wv[4] = 1; wv[5] = 1; mv[7] = 1; mv[8] = 1;
        wv[0] = 1; wv[1] = 1; mv[1] = 1; mv[4] = 1; wv[7] = 1; wv[10] = 1; mv[11] = 1;
        st[7] = 1;
        run_layers(0, 1'b0, 0, done_at);
        check("spurious done cycle", done_at, 14);

        // abort on the second CALC valid of layer 1, then a fresh run
        words_tab[0] = 1; pix_tab[0] = 3;
        words_tab[1] = 2; pix_tab[1] = 3;
        words_tab[2] = 1; pix_tab[2] = 2;
        clear_stim(); random_valids();
        run_layers(2, 1'b0, 1, done_at);
        check("abort no done", done_at, -1);
        clear_stim(); random_valids();
        run_layers(2, 1'b0, 0, done_at);

        // reset in the middle of LOAD, then the single-layer reference again
        words_tab[0] = 3; pix_tab[0] = 2;
        clear_stim(); random_valids();
        run_layers(0, 1'b0, 2, done_at);
        check("reset no done", done_at, -1);
        clear_stim();
        wv[3] = 1; wv[4] = 1; wv[5] = 1; mv[7] = 1; mv[8] = 1;
        run_layers(0, 1'b0, 0, done_at);
        check("post-reset done cycle", done_at, 14);

        // random runs with spurious starts and occasional random aborts
        for (int r = 0; r < 10; r++) begin
            int nl;
            nl = $urandom_range(0, 7);
            for (int i = 0; i < 8; i++) begin
                words_tab[i] = $urandom_range(0, 6);
                pix_tab[i]   = $urandom_range(0, 6);
            end
            clear_stim(); random_valids();
            run_layers(nl, 1'b1, ($urandom_range(0, 3) == 0) ? 3 : 0, done_at);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
